// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared RAM-status, word and arbiter-state types for the CPU-RAM interface.
// Revision 1.0
`default_nettype none

package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter.sv
// mem_arbiter: registered-grant arbiter sharing one RAM port between instruction fetch and data.
// Revision 1.0
`default_nettype none

module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        err
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  arb_state_t       state;
  arb_state_t       state_nxt;
  ramstate_t        rs;
  logic             data_req;
  logic             access;
  logic             fault;
  logic             dwrite;
  logic [CNT_W-1:0] starve_cnt;

  assign rs       = ramstate_t'(ramstate);
  assign data_req = dREN | dWEN;
  assign access   = (rs == ACCESS);
  assign fault    = (rs == ERROR);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (data_req && (starve_cnt < CNT_MAX)) state_nxt = DGNT;
        else if (iREN)                          state_nxt = IGNT;
        else if (data_req)                      state_nxt = DGNT;
      end
      IGNT: if (access || fault || !iREN)     state_nxt = IDLE;
      DGNT: if (access || fault || !data_req) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Write/read direction is latched at grant so the strobes depend on state alone.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      dwrite     <= 1'b0;
      err        <= 1'b0;
      starve_cnt <= '0;
    end else begin
      state <= state_nxt;
      err   <= (state != IDLE) && fault;
      if (state == IDLE && state_nxt == DGNT)
        dwrite <= dWEN;
      if (state == IGNT && access)
        starve_cnt <= '0;
      else if (state == IDLE && !iREN)
        starve_cnt <= '0;
      else if (state == DGNT && access && iREN && (starve_cnt < CNT_MAX))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (state)
      IGNT: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
      end
      DGNT: begin
        ramREN   = ~dwrite;
        ramWEN   = dwrite;
        ramaddr  = daddr;
        ramstore = dstore;
      end
      default: ;
    endcase
  end

  assign iwait = ~(state == IGNT && access);
  assign dwait = ~(state == DGNT && access);
  assign iload = ramload;
  assign dload = ramload;

endmodule

`default_nettype wire
